// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and grant encodings for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LSU  = 2'd2
    } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between IF and LSU requests
//
// Ports:
//   if_valid   in   IF request pending
//   lsu_valid  in   LSU request pending
//   last_lsu   in   last grant went to LSU (only with MEM_ARB_RR_EN)
//   pick_if    out  IF wins this cycle
//   pick_lsu   out  LSU wins this cycle
//
// Macro MEM_ARB_RR_EN: ties alternate based on last_lsu; otherwise LSU always wins ties.
module mem_arb_pick (
    input  logic if_valid,
    input  logic lsu_valid,
`ifdef MEM_ARB_RR_EN
    input  logic last_lsu,
`endif
    output logic pick_if,
    output logic pick_lsu
);

    always_comb begin
        pick_if  = 1'b0;
        pick_lsu = 1'b0;
        if (if_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
            // Tie goes to whichever side did not receive the previous grant.
            if (last_lsu) begin
                pick_if = 1'b1;
            end else begin
                pick_lsu = 1'b1;
            end
`else
            pick_lsu = 1'b1;
`endif
        end else begin
            pick_if  = if_valid;
            pick_lsu = lsu_valid;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory port between IF and LSU
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req_valid/if_req_ready        IF read request handshake, if_addr
//   if_resp_valid/if_rdata           IF response pulse and data
//   lsu_req_valid/lsu_req_ready      LSU request handshake, lsu_addr/wen/wdata/wmask
//   lsu_resp_valid/lsu_rdata         LSU response pulse, data (0 for store ack)
//   mem_req_valid/mem_req_ready      downstream request handshake, latched mem_addr/wen/wdata/wmask
//   mem_resp_valid/mem_rdata         downstream response
//
// Macro MEM_ARB_RR_EN: round-robin tie breaking; undefined gives fixed LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64,
    parameter int MW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_addr,
    output logic          if_resp_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [MW-1:0] lsu_wmask,
    output logic          lsu_resp_valid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [MW-1:0] mem_wmask,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_q, state_d;
    gnt_t          grant_q, grant_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          wen_q,   wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [MW-1:0] wmask_q, wmask_d;

    logic pick_if, pick_lsu;
    logic idle_accept;
    logic resp_fire;

`ifdef MEM_ARB_RR_EN
    logic last_lsu_q, last_lsu_d;
`endif

    mem_arb_pick u_pick (
        .if_valid  (if_req_valid),
        .lsu_valid (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_lsu  (last_lsu_q),
`endif
        .pick_if   (pick_if),
        .pick_lsu  (pick_lsu)
    );

    // Handshake outputs are masked by rst so nothing downstream or upstream
    // sees a transfer in a cycle that is being reset.
    assign idle_accept   = (state_q == IDLE) && !rst;
    assign resp_fire     = (state_q == WAIT) && mem_resp_valid && !rst;

    assign if_req_ready  = idle_accept && pick_if;
    assign lsu_req_ready = idle_accept && pick_lsu;

    assign mem_req_valid = (state_q == REQ) && !rst;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign if_resp_valid  = resp_fire && (grant_q == GNT_IF);
    assign lsu_resp_valid = resp_fire && (grant_q == GNT_LSU);
    assign if_rdata       = if_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = (lsu_resp_valid && !wen_q) ? mem_rdata : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (pick_if) begin
                    grant_d = GNT_IF;
                    addr_d  = if_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = REQ;
                end else if (pick_lsu) begin
                    grant_d = GNT_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= GNT_NONE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Pointer moves on every accepted request, not only on ties.
    always_comb begin
        last_lsu_d = last_lsu_q;
        if (if_req_ready) begin
            last_lsu_d = 1'b0;
        end else if (lsu_req_ready) begin
            last_lsu_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b0;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_addr;
    logic          if_resp_valid;
    logic [DW-1:0] if_rdata;
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [DW-1:0] lsu_wdata;
    logic [MW-1:0] lsu_wmask;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic clear_inputs();
        if_req_valid   = 1'b0;
        if_addr        = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready: got %0b exp 0", if_req_ready); end
        checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready: got %0b exp 0", lsu_req_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %0b exp 0", mem_req_valid); end
        checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_if_resp: got %0b exp 0", if_resp_valid); end
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_lsu_resp: got %0b exp 0", lsu_resp_valid); end
        checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rst_mem_wen: got %0b exp 0", mem_wen); end
        checks++; if (mem_wdata !== 64'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
        checks++; if (mem_wmask !== 8'h0) begin errors++; $display("FAIL rst_mem_wmask: got %h exp 0", mem_wmask); end
        // Stray response in IDLE must be ignored
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h5A5A;
        #1;
        checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL idle_stray_if_resp: got %0b exp 0", if_resp_valid); end
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL idle_stray_lsu_resp: got %0b exp 0", lsu_resp_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_stays_idle: got %0b exp 0", mem_req_valid); end
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL if_ready: got %0b exp 1", if_req_ready); end
        checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL if_lsu_ready: got %0b exp 0", lsu_req_ready); end
        @(negedge clk);
        if_req_valid = 1'b0;
        if_addr      = '1;
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL if_mem_valid: got %0b exp 1", mem_req_valid); end
        checks++; if (mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL if_mem_addr: got %h exp 80000000", mem_addr); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL if_mem_wen: got %0b exp 0", mem_wen); end
        checks++; if (mem_wmask !== 8'h0) begin errors++; $display("FAIL if_mem_wmask: got %h exp 0", mem_wmask); end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0000_0013;
        #1;
        checks++; if (if_resp_valid !== 1'b1) begin errors++; $display("FAIL if_resp_valid: got %0b exp 1", if_resp_valid); end
        checks++; if (if_rdata !== 64'h13) begin errors++; $display("FAIL if_rdata: got %h exp 13", if_rdata); end
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL if_lsu_resp: got %0b exp 0", lsu_resp_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL if_wait_mem_valid: got %0b exp 0", mem_req_valid); end
        @(negedge clk);
        #1;
        checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL if_resp_single: got %0b exp 0", if_resp_valid); end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_lsu_store();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 64'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        mem_req_ready = 1'b1;
        mem_rdata     = 64'h1234;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL st_lsu_ready: got %0b exp 1", lsu_req_ready); end
        checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL st_if_ready: got %0b exp 0", if_req_ready); end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        lsu_wdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        lsu_wmask     = 8'hFF;
        lsu_wen       = 1'b0;
        #1;
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL st_mem_wen: got %0b exp 1", mem_wen); end
        checks++; if (mem_addr !== 64'h8000_1000) begin errors++; $display("FAIL st_mem_addr: got %h exp 80001000", mem_addr); end
        checks++; if (mem_wdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL st_mem_wdata: got %h exp deadbeef", mem_wdata); end
        checks++; if (mem_wmask !== 8'h0F) begin errors++; $display("FAIL st_mem_wmask: got %h exp 0f", mem_wmask); end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        #1;
        checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("FAIL st_lsu_resp: got %0b exp 1", lsu_resp_valid); end
        checks++; if (lsu_rdata !== 64'h0) begin errors++; $display("FAIL st_lsu_rdata: got %h exp 0", lsu_rdata); end
        checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL st_if_resp: got %0b exp 0", if_resp_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL st_lsu_resp_single: got %0b exp 0", lsu_resp_valid); end
    endtask

    task automatic test_priority();
        logic exp_lsu;
        apply_reset();
        // Scenario A: simultaneous request, LSU wins in both modes (RR pointer resets to IF)
        if_req_valid  = 1'b1;
        if_addr       = 64'h1000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h2000;
        lsu_wen       = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL pri_a_lsu_ready: got %0b exp 1", lsu_req_ready); end
        checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL pri_a_if_ready: got %0b exp 0", if_req_ready); end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        #1;
        checks++; if (mem_addr !== 64'h2000) begin errors++; $display("FAIL pri_a_mem_addr: got %h exp 2000", mem_addr); end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hAAAA;
        #1;
        checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("FAIL pri_a_lsu_resp: got %0b exp 1", lsu_resp_valid); end
        checks++; if (lsu_rdata !== 64'hAAAA) begin errors++; $display("FAIL pri_a_lsu_rdata: got %h exp aaaa", lsu_rdata); end
        checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL pri_a_wait_no_accept: got %0b exp 0", if_req_ready); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL pri_a_if_next: got %0b exp 1", if_req_ready); end
        @(negedge clk);
        lsu_req_valid = 1'b1;
        #1;
        checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL pri_a_if_addr: got %h exp 1000", mem_addr); end
        checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL pri_a_req_no_accept: got %0b exp 0", lsu_req_ready); end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hBBBB;
        #1;
        checks++; if (if_rdata !== 64'hBBBB) begin errors++; $display("FAIL pri_a_if_rdata: got %h exp bbbb", if_rdata); end
        // Scenario B: both held valid across 4 transactions
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_lsu = (i % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            @(negedge clk);
            mem_resp_valid = 1'b0;
            #1;
            checks++; if (lsu_req_ready !== exp_lsu) begin errors++; $display("FAIL pri_b%0d_lsu_ready: got %0b exp %0b", i, lsu_req_ready, exp_lsu); end
            checks++; if (if_req_ready !== !exp_lsu) begin errors++; $display("FAIL pri_b%0d_if_ready: got %0b exp %0b", i, if_req_ready, !exp_lsu); end
            @(negedge clk);
            #1;
            checks++; if (mem_addr !== (exp_lsu ? 64'h2000 : 64'h1000)) begin errors++; $display("FAIL pri_b%0d_mem_addr: got %h", i, mem_addr); end
            @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_rdata      = 64'h100 + 64'(i);
            #1;
            checks++; if (lsu_resp_valid !== exp_lsu) begin errors++; $display("FAIL pri_b%0d_lsu_resp: got %0b exp %0b", i, lsu_resp_valid, exp_lsu); end
            checks++; if (if_resp_valid !== !exp_lsu) begin errors++; $display("FAIL pri_b%0d_if_resp: got %0b exp %0b", i, if_resp_valid, !exp_lsu); end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_2000;
        lsu_wen       = 1'b0;
        lsu_wdata     = 64'h0123_4567_89AB_CDEF;
        lsu_wmask     = 8'hF0;
        mem_req_ready = 1'b0;
        #1;
        checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL bp_lsu_ready: got %0b exp 1", lsu_req_ready); end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_valid: got %0b exp 1", i, mem_req_valid); end
            checks++; if (mem_addr !== 64'h8000_2000) begin errors++; $display("FAIL bp_hold%0d_addr: got %h exp 80002000", i, mem_addr); end
            checks++; if (mem_wdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL bp_hold%0d_wdata: got %h", i, mem_wdata); end
            checks++; if (mem_wmask !== 8'hF0) begin errors++; $display("FAIL bp_hold%0d_wmask: got %h exp f0", i, mem_wmask); end
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %0b exp 1", mem_req_valid); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL bp_wait%0d_resp: got %0b exp 0", i, lsu_resp_valid); end
            checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_wait%0d_valid: got %0b exp 0", i, mem_req_valid); end
            @(negedge clk);
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h5555;
        #1;
        checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp: got %0b exp 1", lsu_resp_valid); end
        checks++; if (lsu_rdata !== 64'h5555) begin errors++; $display("FAIL bp_rdata: got %h exp 5555", lsu_rdata); end
        @(negedge clk);
        #1;
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL bp_resp_single: got %0b exp 0", lsu_resp_valid); end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0040;
        mem_req_ready = 1'b1;
        #1;
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL ab_if_ready: got %0b exp 1", if_req_ready); end
        @(negedge clk);
        if_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL ab_rst_if_resp: got %0b exp 0", if_resp_valid); end
        @(negedge clk);
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h77;
        #1;
        checks++; if (if_resp_valid !== 1'b0) begin errors++; $display("FAIL ab_late_if_resp: got %0b exp 0", if_resp_valid); end
        checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL ab_late_lsu_resp: got %0b exp 0", lsu_resp_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL ab_mem_valid: got %0b exp 0", mem_req_valid); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        if_req_valid   = 1'b1;
        if_addr        = 64'h8000_0080;
        #1;
        checks++; if (if_req_ready !== 1'b1) begin errors++; $display("FAIL ab_idle_accept: got %0b exp 1", if_req_ready); end
        @(negedge clk);
        if_req_valid = 1'b0;
        #1;
        checks++; if (mem_addr !== 64'h8000_0080) begin errors++; $display("FAIL ab_new_addr: got %h exp 80000080", mem_addr); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_if_read();
        test_lsu_store();
        test_priority();
        test_backpressure();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
